// File: rtl/parity_pkg.sv
// Shared constants and types for the parity slot buffer.
package parity_pkg;

  localparam int unsigned DW_DEF    = 4;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_t;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/parity_queue.sv
// Circular FIFO with wrap-bit pointers; push to a full queue and pop from an empty one are ignored.
module parity_queue #(
  parameter int unsigned DW    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign head    = mem[rptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/parity_slot_buffer.sv
// Captures even/odd grant edges into two queues and drains them round-robin through one
// registered valid/ready port. Optional per-parity push counters under `PARITY_STATS_EN.
module parity_slot_buffer
  import parity_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  input  logic          even_en,
  input  logic          odd_en,
  output logic [DW-1:0] out_data,
  output logic          out_parity,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          even_full,
  output logic          odd_full,
  output logic          drop
`ifdef PARITY_STATS_EN
  ,
  output logic [CNT_W-1:0] even_cnt,
  output logic [CNT_W-1:0] odd_cnt
`endif
);

  logic          even_q;
  logic          odd_q;
  logic          even_edge;
  logic          odd_edge;
  logic          even_push;
  logic          odd_push;
  logic          even_pop;
  logic          odd_pop;
  logic          even_empty;
  logic          odd_empty;
  logic [DW-1:0] even_head;
  logic [DW-1:0] odd_head;
  logic          load;
  logic          drop_d;
  parity_t       sel;
  parity_t       pref_q;

  assign even_edge = even_en && !even_q;
  assign odd_edge  = odd_en && !odd_q;

  // Fullness comes straight from the pointer registers, so a same-cycle pop never frees a slot.
  assign even_push = even_edge && !odd_edge && !even_full;
  assign odd_push  = odd_edge && !even_edge && !odd_full;

  always_comb begin
    drop_d = (even_edge && odd_edge) ||
             (even_edge && !odd_edge && even_full) ||
             (odd_edge && !even_edge && odd_full);

    load = (!out_valid || out_ready) && !(even_empty && odd_empty);

    if (!even_empty && !odd_empty) begin
      sel = pref_q;
    end else if (!even_empty) begin
      sel = EVEN;
    end else begin
      sel = ODD;
    end

    even_pop = load && (sel == EVEN);
    odd_pop  = load && (sel == ODD);
  end

  parity_queue #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_even_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (even_push),
    .push_data (d),
    .pop       (even_pop),
    .full      (even_full),
    .empty     (even_empty),
    .head      (even_head)
  );

  parity_queue #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_odd_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (odd_push),
    .push_data (d),
    .pop       (odd_pop),
    .full      (odd_full),
    .empty     (odd_empty),
    .head      (odd_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      even_q     <= 1'b0;
      odd_q      <= 1'b0;
      drop       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_parity <= 1'b0;
      pref_q     <= EVEN;
    end else begin
      even_q <= even_en;
      odd_q  <= odd_en;
      drop   <= drop_d;
      if (load) begin
        out_valid  <= 1'b1;
        out_data   <= (sel == EVEN) ? even_head : odd_head;
        out_parity <= (sel == ODD);
        pref_q     <= (sel == EVEN) ? ODD : EVEN;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      even_cnt <= '0;
      odd_cnt  <= '0;
    end else begin
      if (even_push) even_cnt <= sat_inc(even_cnt);
      if (odd_push)  odd_cnt  <= sat_inc(odd_cnt);
    end
  end
`endif

endmodule
